// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================
// aes_pkg : shared types and constants for the inverse AES core
// Revision: 1.0
// ============================================================
package aes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WORD  = 3'd1,
      ST_CAPT  = 3'd2,
      ST_FINAL = 3'd3,
      ST_DONE  = 3'd4
   } inv_ctrl_state_t;

   localparam logic [1:0] AES_MODE_128 = 2'b00;
   localparam logic [1:0] AES_MODE_192 = 2'b01;
   localparam logic [1:0] AES_MODE_256 = 2'b10;

   localparam logic [3:0] AES_NR_128 = 4'd10;
   localparam logic [3:0] AES_NR_192 = 4'd12;
   localparam logic [3:0] AES_NR_256 = 4'd14;

   // Unknown encodings fall back to AES-128.
   function automatic logic [3:0] aes_nr(input logic [1:0] mode);
      case (mode)
         AES_MODE_192: aes_nr = AES_NR_192;
         AES_MODE_256: aes_nr = AES_NR_256;
         default:      aes_nr = AES_NR_128;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round_ctrl.sv
`default_nettype none
// ============================================================
// aes_inv_round_ctrl : round sequencer for the word-serial inverse AES datapath
// Revision: 1.0
// ============================================================
module aes_inv_round_ctrl
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [1:0]   in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [3:0]   rk_index,
   input  logic [127:0] rk_data,
   output logic [3:0]   rd_round,
   output logic [1:0]   rd_mode,
   output logic [127:0] rd_round_key,
   output logic [127:0] rd_data_in,
   output logic [1:0]   rd_width_sel,
   input  logic [127:0] rd_data_out
);

   inv_ctrl_state_t st;
   logic [127:0]    blk_state;
   logic [3:0]      round;
   logic [1:0]      mode;
   logic [1:0]      word_cnt;
   logic [3:0]      round_nxt;

   assign round_nxt = round + 4'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= ST_IDLE;
         blk_state <= '0;
         round     <= '0;
         mode      <= AES_MODE_128;
         word_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (in_valid) begin
                  blk_state <= in_data;
                  // Mode 11 has no last-round flag in the datapath; run it as AES-128.
                  mode      <= (in_mode == 2'b11) ? AES_MODE_128 : in_mode;
                  round     <= '0;
                  word_cnt  <= '0;
                  st        <= ST_WORD;
               end
            end
            ST_WORD: begin
               word_cnt <= word_cnt + 2'd1;
               if (word_cnt == 2'd3)
                  st <= ST_CAPT;
            end
            ST_CAPT: begin
               blk_state <= rd_data_out;
               round     <= round_nxt;
               word_cnt  <= '0;
               st        <= (round_nxt == aes_nr(mode)) ? ST_FINAL : ST_WORD;
            end
            ST_FINAL: begin
               out_data  <= rd_data_out;
               out_valid <= 1'b1;
               st        <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  st        <= ST_IDLE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign in_ready     = (st == ST_IDLE);
   assign rk_index     = aes_nr(mode) - round;
   assign rd_round     = round;
   assign rd_mode      = mode;
   assign rd_round_key = rk_data;
   assign rd_data_in   = blk_state;
   // Most-significant word first; parked on word 3 outside WORD.
   assign rd_width_sel = (st == ST_WORD) ? (2'd3 - word_cnt) : 2'd3;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_round_ctrl.sv
`default_nettype none
// ============================================================
// tb_aes_inv_round_ctrl : scoreboard bench with a behavioural word-serial datapath
// Revision: 1.0
// ============================================================
module tb_aes_inv_round_ctrl;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [1:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   rk_index;
   logic [127:0] rk_data;
   logic [3:0]   rd_round;
   logic [1:0]   rd_mode;
   logic [127:0] rd_round_key;
   logic [127:0] rd_data_in;
   logic [1:0]   rd_width_sel;
   logic [127:0] rd_data_out;

   int checks   = 0;
   int failures = 0;

   logic [127:0] keys [16];
   logic [127:0] acc;
   logic [127:0] sb [$];
   logic [127:0] last_exp;

   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_X  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT_Y  = 128'hdeadbeefcafef00d0badc0de13579bdf;

   aes_inv_round_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rk_index(rk_index), .rk_data(rk_data),
      .rd_round(rd_round), .rd_mode(rd_mode), .rd_round_key(rd_round_key),
      .rd_data_in(rd_data_in), .rd_width_sel(rd_width_sel), .rd_data_out(rd_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] nr_of(input logic [1:0] m);
      case (m)
         2'b01:   nr_of = 4'd12;
         2'b10:   nr_of = 4'd14;
         default: nr_of = 4'd10;
      endcase
   endfunction

   // One output word of the stand-in round: mixes a neighbour word so word order matters.
   function automatic logic [31:0] dp_word(input logic [127:0] s, input logic [127:0] k,
                                           input int r, input int w);
      logic [31:0] a, b;
      a = s[w*32 +: 32];
      b = s[((w + 1) % 4)*32 +: 32];
      dp_word = a ^ {b[26:0], b[31:27]} ^ k[(3 - w)*32 +: 32] ^ (32'(r) * 32'h9e3779b9);
   endfunction

   function automatic logic [127:0] ref_model(input logic [127:0] ct, input logic [1:0] m);
      logic [127:0] s, t;
      int n;
      n = int'(nr_of(m));
      s = ct;
      for (int r = 0; r < n; r++) begin
         for (int w = 0; w < 4; w++)
            t[w*32 +: 32] = dp_word(s, keys[n - r], r, w);
         s = t;
      end
      ref_model = s ^ keys[0];
   endfunction

   assign rk_data = keys[rk_index];

   always @(posedge clk)
      acc[rd_width_sel*32 +: 32] <= dp_word(rd_data_in, rd_round_key, int'(rd_round), int'(rd_width_sel));

   assign rd_data_out = (rd_round == nr_of(rd_mode)) ? (rd_data_in ^ rd_round_key) : acc;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_block(input logic [127:0] ct, input logic [1:0] m);
      check("in_ready_pre", 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = ct;
      in_mode  = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(ref_model(ct, (m == 2'b11) ? 2'b00 : m));
   endtask

   // Entered one cycle after the accept edge (cycle 1).
   task automatic wait_out(input int exp_lat, input logic [1:0] m, input bit chk_rk, input bit chk_m11);
      int cyc;
      int n;
      n   = int'(nr_of(m));
      cyc = 1;
      while (!out_valid && cyc < 300) begin
         if (chk_rk)  check("rk_index", 128'(rk_index), 128'(n - (cyc - 1) / 5));
         if (chk_m11) check("rd_mode_m11", 128'(rd_mode), 128'd0);
         @(posedge clk); #1;
         cyc++;
      end
      if (!out_valid) begin
         check("out_valid_timeout", 128'd0, 128'd1);
      end else begin
         check("latency", 128'(cyc), 128'(exp_lat));
         if (sb.size() == 0) begin
            check("sb_empty", 128'd0, 128'd1);
         end else begin
            last_exp = sb.pop_front();
            check("out_data", out_data, last_exp);
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_in_ready", 128'(in_ready), 128'd1);
      check("idle_out_valid", 128'(out_valid), 128'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'b00;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         keys[i] = {$urandom, $urandom, $urandom, $urandom};
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_rd_data_in", rd_data_in, 128'd0);
      check("rst_rd_round", 128'(rd_round), 128'd0);
      check("rst_rd_mode", 128'(rd_mode), 128'd0);
      check("rst_width_sel", 128'(rd_width_sel), 128'd3);
      check("rst_rk_index", 128'(rk_index), 128'd10);

      start_block(CT_C1, 2'b00);
      wait_out(52, 2'b00, 1'b0, 1'b0);
      release_out();

      start_block(CT_C3, 2'b10);
      wait_out(72, 2'b10, 1'b1, 1'b0);
      release_out();

      start_block(CT_C1, 2'b11);
      wait_out(52, 2'b00, 1'b0, 1'b1);
      release_out();

      // Backpressure with a second block waiting at the input.
      start_block(CT_X, 2'b01);
      wait_out(62, 2'b01, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = CT_Y;
      in_mode  = 2'b00;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", 128'(out_valid), 128'd1);
         check("bp_out_data", out_data, last_exp);
         check("bp_in_ready", 128'(in_ready), 128'd0);
      end
      release_out();
      sb.push_back(ref_model(CT_Y, 2'b00));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_accepted", 128'(in_ready), 128'd0);
      check("bp_state_loaded", rd_data_in, CT_Y);
      wait_out(52, 2'b00, 1'b0, 1'b0);
      release_out();

      // Reset in round 5 with word_cnt 2 (cycle 28 after accept).
      start_block(CT_C1, 2'b00);
      repeat (27) @(posedge clk);
      #1;
      check("mid_round", 128'(rd_round), 128'd5);
      check("mid_width_sel", 128'(rd_width_sel), 128'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      check("mr_in_ready", 128'(in_ready), 128'd1);
      check("mr_out_valid", 128'(out_valid), 128'd0);
      check("mr_rd_round", 128'(rd_round), 128'd0);
      check("mr_rd_data_in", rd_data_in, 128'd0);
      start_block(CT_C1, 2'b00);
      wait_out(52, 2'b00, 1'b0, 1'b0);
      release_out();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Sequencer for the word-serial inverse AES datapath. It accepts one ciphertext block over a valid/ready handshake and holds the round state register. For every round it drives `aes_inv_rounddata` with the round number, mode, round key and 32-bit word select, and feeds `data_out` back as the next `data_in`. After the last round it presents the plaintext on a valid/ready output.

## Interface
- No parameters. Nr values and the mode encoding come from the package.
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  ciphertext block offered.
- `in_ready`  out  1  block can be accepted.
- `in_data`  in  128  ciphertext.
- `in_mode`  in  2  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
- `out_valid`  out  1  plaintext available.
- `out_ready`  in  1  consumer takes plaintext.
- `out_data`  out  128  plaintext.
- `rk_index`  out  4  key-schedule index requested.
- `rk_data`  in  128  key for `rk_index`, combinational, same cycle.
- `rd_round`  out  4  to datapath `round`.
- `rd_mode`  out  2  to datapath `mode`.
- `rd_round_key`  out  128  to datapath `round_key`; equals `rk_data`.
- `rd_data_in`  out  128  to datapath `data_in`; equals the state register.
- `rd_width_sel`  out  2  to datapath `width_sel`.
- `rd_data_out`  in  128  from datapath `data_out`.

## Operation
- Nr is 10, 12 or 14, taken from the latched mode.
- `in_mode` = 11 is latched as 00 and processed as AES-128. The datapath has no last-round flag for mode 11 and must never see it.
- Round r uses key index Nr − r: round 0 uses key Nr, round Nr uses key 0.
  - `rk_index` = Nr − `rd_round`, combinational from registered round and mode.
- States:
  - **IDLE**
    - `in_ready` = 1.
    - On `in_valid`: state ← `in_data`, mode latched, round ← 0, word_cnt ← 0. Go to WORD.
  - **WORD**
    - `rd_width_sel` = 3 − word_cnt; words go most-significant first, 3, 2, 1, 0.
    - word_cnt increments each cycle.
    - After word_cnt = 3, go to CAPT.
  - **CAPT**
    - The accumulator is full and `rd_data_out` is valid. State ← `rd_data_out`, round ← round + 1, word_cnt ← 0.
    - Go to FINAL if the new round = Nr, else to WORD.
  - **FINAL**
    - The datapath outputs `ark_out` combinationally.
    - `out_data` ← `rd_data_out`. Go to DONE.
  - **DONE**
    - `out_valid` = 1.
    - On `out_ready`, go to IDLE.
- `in_ready` is 0 in every state except IDLE. `in_valid` in those states is ignored and causes no side effects.
- The datapath accumulator has no reset or enable. Each round rewrites all four words before CAPT, so stale contents are never used.
- In IDLE and DONE, `rd_width_sel` = 3 and the datapath outputs are don't-care.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1 in the first cycle after reset.
  - `out_valid` = 0, `out_data` = 0.
  - state register 0, so `rd_data_in` = 0.
  - `rd_round` = 0, `rd_mode` = 00, `rd_width_sel` = 3, `rk_index` = 10.
- Each round 0..Nr−1 takes 5 cycles: 4 WORD and 1 CAPT. FINAL takes 1 cycle.
- Counting the accept edge as cycle 0, `out_valid` first rises in cycle 5·Nr + 2:
  - AES-128: cycle 52.
  - AES-192: cycle 62.
  - AES-256: cycle 72.
- `out_valid` and `out_data` stay stable while `out_ready` is 0.
- When `out_valid` and `out_ready` are both 1, the next cycle is IDLE with `in_ready` = 1. Minimum period is 5·Nr + 3 cycles per block.
- `rst_n` low in any state returns to IDLE at the next edge, with all reset values. A partial result is discarded and `out_valid` is never raised for it.

## Structure
- `aes_pkg` holds:
  - the state enum `inv_ctrl_state_t`,
  - mode constants `AES_MODE_128/192/256`,
  - Nr constants `AES_NR_128/192/256` = 10/12/14.
- No internal sub-module; the Nr lookup is a function in `aes_pkg`.
- The integration top `aes_inv_core` instantiates this block and `aes_inv_rounddata`. The key store is external.

## Test plan
- FIPS-197 C.1 with the datapath and expanded key of 000102…0f:
  - ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, mode 00 → `out_data` = 00112233445566778899aabbccddeeff, `out_valid` at cycle 52.
- FIPS-197 C.3, key 000102…1f:
  - ciphertext 8ea2b7ca516745bfeafc49904b496089, mode 10 → same plaintext at cycle 72.
  - `rk_index` sequence 14, 13, …, 0, each held for 5 cycles (last for 1).
- Mode 11 with the C.1 vectors:
  - `rd_mode` = 00, result as in C.1, `out_valid` at cycle 52.
- Backpressure: `out_ready` held 0 for 20 cycles after `out_valid`:
  - `out_valid`/`out_data` stable.
  - A second block offered meanwhile is not accepted and is taken only in the IDLE cycle after the handshake.
- Reset mid-run: `rst_n` low at round 5, WORD word_cnt 2:
  - next cycle IDLE, `in_ready` = 1, `out_valid` = 0, `rd_round` = 0, `rd_data_in` = 0.
  - A fresh C.1 run then produces the correct plaintext.
